// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 stream writer.
// Optional macro HUB75_ERR_CNT_EN enables the saturating error counter.
package hub75_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int PIX_BPP_LP = 8;

    typedef struct packed {
        logic [PIX_BPP_LP-1:0] r;
        logic [PIX_BPP_LP-1:0] g;
        logic [PIX_BPP_LP-1:0] b;
    } pixel_t;

    localparam int ERR_CNT_W = 16;

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_stream_writer_if.sv
// Valid/ready pixel stream carrying start-of-frame and end-of-line markers.
// The writer consumes it through the slave modport.
interface hub75_stream_writer_if #(
    parameter int bpp_p = 8
);
    logic               valid;
    logic               ready;
    logic [3*bpp_p-1:0] data;
    logic               sof;
    logic               eol;

    modport master (
        output valid, data, sof, eol,
        input  ready
    );

    modport slave (
        input  valid, data, sof, eol,
        output ready
    );
endinterface

// File: rtl/hub75_pos_counter.sv
// x/y position and linear address counters for the stream writer.
// i_restart makes the increment start from pixel (0,0).
module hub75_pos_counter
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    localparam int XW = cw(hpixel_p),
    localparam int YW = cw(vpixel_p),
    localparam int AW = cw(hpixel_p * vpixel_p)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_restart,
    input  logic          i_inc,
    input  logic          i_wrap,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [AW-1:0] o_addr
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic [XW-1:0] w_bx;
    logic [YW-1:0] w_by;
    logic [AW-1:0] w_ba;

    assign w_bx = i_restart ? '0 : r_x;
    assign w_by = i_restart ? '0 : r_y;
    assign w_ba = i_restart ? '0 : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_inc) begin
            r_x    <= w_bx + XW'(1);
            r_y    <= w_by;
            r_addr <= w_ba + AW'(1);
        end else if (i_wrap) begin
            r_x    <= '0;
            r_y    <= w_by + YW'(1);
            r_addr <= w_ba + AW'(1);
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;

endmodule

// File: rtl/hub75_stream_writer.sv
// Pixel stream to frame-buffer write port with framing checks and resync.
// HUB75_ERR_CNT_EN adds i_err_clr and a saturating o_err_cnt.
module hub75_stream_writer
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8,
    localparam int addr_width_p = cw(hpixel_p * vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    hub75_stream_writer_if.slave    s_if,
    output logic [addr_width_p-1:0] o_wr_addr,
    output logic [3*bpp_p-1:0]      o_wr_data,
    output logic                    o_wr_en,
    output logic                    o_frame_done,
    output logic                    o_err,
`ifdef HUB75_ERR_CNT_EN
    input  logic                    i_err_clr,
    output logic [ERR_CNT_W-1:0]    o_err_cnt,
`endif
    output logic                    o_busy
);

    localparam int XW = cw(hpixel_p);
    localparam int YW = cw(vpixel_p);
    localparam logic [XW-1:0] X_LAST = XW'(hpixel_p - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(vpixel_p - 1);

    state_t r_state;
    state_t w_state_n;

    logic [XW-1:0]           w_x;
    logic [YW-1:0]           w_y;
    logic [addr_width_p-1:0] w_addr;
    logic w_acc, w_take, w_x_last, w_y_last, w_eol_ok;
    logic w_wr, w_err, w_done, w_inc, w_wrap, w_clr;

    logic [addr_width_p-1:0] r_wr_addr;
    logic [3*bpp_p-1:0]      r_wr_data;
    logic                    r_wr_en;
    logic                    r_done;
    logic                    r_err;

    assign s_if.ready = i_enable;
    assign w_acc      = s_if.valid & i_enable;
    assign w_take     = w_acc & (s_if.sof | (r_state == ACTIVE));

    // A sof beat is judged as pixel (0,0) regardless of the counters.
    assign w_x_last = s_if.sof ? (hpixel_p == 1) : (w_x == X_LAST);
    assign w_y_last = s_if.sof ? (vpixel_p == 1) : (w_y == Y_LAST);
    assign w_eol_ok = (s_if.eol == w_x_last);

    hub75_pos_counter #(
        .hpixel_p (hpixel_p),
        .vpixel_p (vpixel_p)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_restart (s_if.sof),
        .i_inc     (w_inc),
        .i_wrap    (w_wrap),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_addr    (w_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_wr      = 1'b0;
        w_err     = 1'b0;
        w_done    = 1'b0;
        w_inc     = 1'b0;
        w_wrap    = 1'b0;
        w_clr     = 1'b0;
        if (w_take) begin
            w_state_n = ACTIVE;
            w_err     = s_if.sof & (r_state == ACTIVE);
            unique case (1'b1)
                !w_eol_ok: begin
                    w_err     = 1'b1;
                    w_clr     = 1'b1;
                    w_state_n = WAIT_SOF;
                end
                w_eol_ok & w_x_last & w_y_last: begin
                    w_wr      = 1'b1;
                    w_done    = 1'b1;
                    w_clr     = 1'b1;
                    w_state_n = WAIT_SOF;
                end
                w_eol_ok & w_x_last & !w_y_last: begin
                    w_wr   = 1'b1;
                    w_wrap = 1'b1;
                end
                default: begin
                    w_wr  = 1'b1;
                    w_inc = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_wr;
            r_done  <= w_done;
            r_err   <= w_err;
            if (w_wr) begin
                r_wr_addr <= s_if.sof ? '0 : w_addr;
                r_wr_data <= s_if.data;
            end
        end
    end

`ifdef HUB75_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_en      = r_wr_en;
    assign o_frame_done = r_done;
    assign o_err        = r_err;
    assign o_busy       = (r_state == ACTIVE);

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Scoreboard bench for hub75_stream_writer on a 4x2 frame.
// Reference model tracks the expected pixel index within the frame.
module tb_hub75_stream_writer;
    import hub75_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int B  = 8;
    localparam int AW = cw(H * V);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_enable = 1'b0;
    logic [AW-1:0]  o_wr_addr;
    logic [3*B-1:0] o_wr_data;
    logic o_wr_en, o_frame_done, o_err, o_busy;
`ifdef HUB75_ERR_CNT_EN
    logic i_err_clr = 1'b0;
    logic [ERR_CNT_W-1:0] o_err_cnt;
`endif

    hub75_stream_writer_if #(.bpp_p(B)) s_if ();

    always #5 clk = ~clk;

    hub75_stream_writer #(
        .hpixel_p (H),
        .vpixel_p (V),
        .bpp_p    (B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .s_if         (s_if),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_wr_en      (o_wr_en),
        .o_frame_done (o_frame_done),
        .o_err        (o_err),
`ifdef HUB75_ERR_CNT_EN
        .i_err_clr    (i_err_clr),
        .o_err_cnt    (o_err_cnt),
`endif
        .o_busy       (o_busy)
    );

    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          done;
    } wr_t;

    wr_t exp_q[$];
    int  err_pend = 0;
    int  total = 0;
    int  bad = 0;
    bit  in_frame = 0;
    int  p = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame semantics: pixel index p must see eol exactly at p%H == H-1.
    function automatic void model(input bit sof, input bit eol,
                                  input logic [23:0] d);
        bit e;
        e = 0;
        if (sof) begin
            if (in_frame) e = 1;
            in_frame = 1;
            p = 0;
        end
        if (in_frame) begin
            if (eol != ((p % H) == H - 1)) begin
                e = 1;
                in_frame = 0;
            end else begin
                exp_q.push_back('{p, d, p == H * V - 1});
                if (p == H * V - 1) in_frame = 0;
                p++;
            end
        end
        if (e) err_pend++;
    endfunction

    task automatic drive(input bit v, input bit sof, input bit eol,
                         input bit en);
        pixel_t px;
        @(posedge clk);
        #1;
        check("busy", o_busy, in_frame);
        px = pixel_t'($urandom);
        s_if.valid = v;
        s_if.sof   = sof;
        s_if.eol   = eol;
        s_if.data  = px;
        i_enable   = en;
        #1;
        check("ready", s_if.ready, en);
        if (v && en) model(sof, eol, px);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
    endtask

    task automatic good_frame();
        for (int i = 0; i < H * V; i++)
            drive(1, i == 0, (i % H) == H - 1, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", o_wr_addr, 32'hFFFF);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", o_wr_addr, w.addr);
                    check("wr_data", o_wr_data, w.data);
                    check("frame_done", o_frame_done, w.done);
                end
            end else if (o_frame_done) begin
                check("done_without_wr", o_frame_done, 0);
            end
            if (o_err) begin
                if (err_pend == 0) check("unexpected_err", o_err, 0);
                else err_pend--;
            end
        end
    end

    initial begin
        bit sof, eol, v, en;
        int g;
        s_if.valid = 0;
        s_if.sof   = 0;
        s_if.eol   = 0;
        s_if.data  = '0;
        #2;
        check("rst_addr", o_wr_addr, 0);
        check("rst_data", o_wr_data, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_done", o_frame_done, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
        #20 rst_n = 1;

        good_frame();
        idle(2);

        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
        good_frame();
        idle(2);

        for (int i = 0; i < H * V; i++) drive(1, i == 0, i == 2, 1);
        good_frame();
        idle(2);

        for (int i = 0; i < H * V; i++)
            drive(1, i == 0 || i == 5, (i % H) == H - 1, 1);
        good_frame();
        idle(2);

        for (int i = 0; i < 4; i++) drive(1, i == 0, i == 3, 1);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
        for (int i = 4; i < H * V; i++) drive(1, 0, i == 7, 1);
        idle(2);

        for (int i = 0; i < 6; i++) drive(1, i == 0, i == 3, 1);
        idle(1);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("mid_rst_wr_en", o_wr_en, 0);
        check("mid_rst_addr", o_wr_addr, 0);
        check("mid_rst_data", o_wr_data, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_q", exp_q.size(), 0);
        in_frame = 0;
        err_pend = 0;
        exp_q.delete();
        #20 rst_n = 1;
        drive(1, 0, 0, 1);
        good_frame();
        idle(2);

        g = 0;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom % 4) != 0;
            en  = ($urandom % 5) != 0;
            sof = (g == 0) || (($urandom % 40) == 0);
            eol = ((g % H) == H - 1) ^ (($urandom % 30) == 0);
            drive(v, sof, eol, en);
            if (v && en) g = (g + 1) % (H * V);
        end
        idle(3);

`ifdef HUB75_ERR_CNT_EN
        i_err_clr = 1;
        idle(1);
        i_err_clr = 0;
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 1);
        idle(2);
        check("err_cnt3", o_err_cnt, 3);
        i_err_clr = 1;
        drive(1, 1, 1, 1);
        idle(1);
        i_err_clr = 0;
        idle(1);
        check("err_cnt_clr", o_err_cnt, 0);
`endif

        idle(3);
        check("exp_q_empty", exp_q.size(), 0);
        check("err_pend_zero", err_pend, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
